// File: rtl/inst_cache_refill_ctrl.sv
// Instruction cache refill controller: tag compare against the fetch address,
// line refill from instruction memory one word at a time, and the
// invalidate-all sweep of the tag RAM after reset or on a flush request.
module inst_cache_refill_ctrl #(
    parameter int  ADDR_W         = 32,
    parameter int  INDEX_W        = 6,
    parameter int  WORDS_PER_LINE = 4,
    localparam int WOFF_W         = $clog2(WORDS_PER_LINE),
    localparam int TAG_W          = ADDR_W - INDEX_W - WOFF_W - 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cpu_req,
    input  logic [ADDR_W-1:0]  cpu_addr,
    output logic               cpu_ready,
    input  logic               flush,
    output logic               busy,
    output logic               tag_we,
    output logic [INDEX_W-1:0] tag_index,
    output logic               tag_valid_in,
    output logic [TAG_W-1:0]   tag_in,
    input  logic               tag_valid_out,
    input  logic [TAG_W-1:0]   tag_out,
    output logic               data_we,
    output logic [INDEX_W-1:0] data_index,
    output logic [WOFF_W-1:0]  data_word_sel,
    output logic [31:0]        data_wdata,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [31:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        UPDATE = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    localparam logic [WOFF_W-1:0]  LAST_WORD = WOFF_W'(WORDS_PER_LINE - 1);
    localparam logic [INDEX_W-1:0] LAST_SET  = {INDEX_W{1'b1}};

    state_t             state, next_state;
    logic               flush_pending, next_pending;
    logic [WOFF_W-1:0]  word_cnt, next_word_cnt;
    logic [INDEX_W-1:0] flush_cnt, next_flush_cnt;
    logic [TAG_W-1:0]   lat_tag, next_lat_tag;
    logic [INDEX_W-1:0] lat_index, next_lat_index;

    logic [INDEX_W-1:0] addr_index;
    logic [TAG_W-1:0]   addr_tag;
    logic               hit;
    logic               offset_bits_unused;

    // Byte and word offsets play no part in the tag lookup.
    assign addr_index         = cpu_addr[WOFF_W+2 +: INDEX_W];
    assign addr_tag           = cpu_addr[ADDR_W-1 -: TAG_W];
    assign offset_bits_unused = ^cpu_addr[WOFF_W+1:0];
    assign hit                = tag_valid_out && (tag_out == addr_tag);

    // State register and counters; reset forces a full invalidate sweep next.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            flush_pending <= 1'b1;
            word_cnt      <= '0;
            flush_cnt     <= '0;
            lat_tag       <= '0;
            lat_index     <= '0;
        end else begin
            state         <= next_state;
            flush_pending <= next_pending;
            word_cnt      <= next_word_cnt;
            flush_cnt     <= next_flush_cnt;
            lat_tag       <= next_lat_tag;
            lat_index     <= next_lat_index;
        end
    end

    // Next-state and output decode; outputs are forced quiet while reset is low
    // so an in-flight refill or sweep is dropped immediately.
    always_comb begin
        next_state     = state;
        next_pending   = flush_pending | flush;
        next_word_cnt  = word_cnt;
        next_flush_cnt = flush_cnt;
        next_lat_tag   = lat_tag;
        next_lat_index = lat_index;

        cpu_ready      = 1'b0;
        tag_we         = 1'b0;
        tag_index      = '0;
        tag_valid_in   = 1'b0;
        tag_in         = '0;
        data_we        = 1'b0;
        data_index     = '0;
        data_word_sel  = '0;
        data_wdata     = '0;
        mem_req        = 1'b0;
        mem_addr       = '0;

        case (state)
            IDLE: begin
                tag_index = addr_index;
                if (flush || flush_pending) begin
                    next_state   = FLUSH;
                    next_pending = 1'b0;
                end else if (cpu_req && hit) begin
                    cpu_ready = 1'b1;
                end else if (cpu_req) begin
                    next_lat_tag   = addr_tag;
                    next_lat_index = addr_index;
                    next_word_cnt  = '0;
                    next_state     = REFILL;
                end
            end
            REFILL: begin
                tag_index     = lat_index;
                mem_req       = 1'b1;
                mem_addr      = {lat_tag, lat_index, word_cnt, 2'b00};
                data_index    = lat_index;
                data_word_sel = word_cnt;
                if (mem_ack) begin
                    data_we       = 1'b1;
                    data_wdata    = mem_rdata;
                    next_word_cnt = word_cnt + WOFF_W'(1);
                    if (word_cnt == LAST_WORD) begin
                        next_state = UPDATE;
                    end
                end
            end
            UPDATE: begin
                tag_index    = lat_index;
                tag_we       = 1'b1;
                tag_valid_in = 1'b1;
                tag_in       = lat_tag;
                next_state   = IDLE;
            end
            FLUSH: begin
                tag_index      = flush_cnt;
                tag_we         = 1'b1;
                next_flush_cnt = flush_cnt + INDEX_W'(1);
                if (flush_cnt == LAST_SET) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        busy = (state != IDLE) || flush_pending;

        if (!reset_n) begin
            cpu_ready     = 1'b0;
            busy          = 1'b1;
            tag_we        = 1'b0;
            tag_index     = '0;
            tag_valid_in  = 1'b0;
            tag_in        = '0;
            data_we       = 1'b0;
            data_index    = '0;
            data_word_sel = '0;
            data_wdata    = '0;
            mem_req       = 1'b0;
            mem_addr      = '0;
        end
    end

endmodule
